prog_store_seq: RTL
===================

# prog_store_seq

Parametrised program store with built-in fetch sequencer for the video display processor's assembler path. The host loads instruction words by address; on `run`, the block streams the stored program in address order to the downstream decoder over a valid/ready port, with jump, halt and end-of-program handling. It replaces the fixed 16x32 store: width and depth are generic, and the host read path is registered instead of tri-stated.

## Interface
- `DATA_W`, 32, instruction word width.
- `ADDR_W`, 4, address width; depth = 2**ADDR_W words.
- `c` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `str` in 1: host write strobe.
- `ld` in 1: host read strobe.
- `a` in ADDR_W: host address for `str` and `ld`.
- `d_in` in DATA_W: host write data.
- `d` out DATA_W: registered host read data.
- `d_vld` out 1: `d` valid, one-cycle pulse.
- `prog_clr` in 1: clears `prog_len` and `err`.
- `run` in 1: start or restart fetch from address 0.
- `halt` in 1: abort fetch, return to IDLE.
- `jmp` in 1: redirect fetch.
- `jmp_addr` in ADDR_W: jump target.
- `f_rdy` in 1: downstream ready.
- `f_vld` out 1: fetch word valid.
- `f_data` out DATA_W: fetched word.
- `f_pc` out ADDR_W: address of `f_data`.
- `prog_len` out ADDR_W+1: highest written address + 1.
- `busy` out 1: high in RUN.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Host write: `str` in IDLE or DONE writes `d_in` to `mem[a]` and sets `prog_len <= max(prog_len, a+1)`. `str` in RUN is dropped: no write, and `err` is set.
- Host read: `ld` is accepted in any state. The read is read-before-write, so `str` and `ld` to the same address in the same cycle return the old word.
- `prog_clr` zeroes `prog_len` and `err`. Memory contents are retained. `prog_clr` is ignored in RUN.
- `run` in IDLE or DONE with `prog_len != 0`: go to RUN and set `pc <= 0`. With `prog_len == 0`: stay in the current state and set `err`. `run` in RUN is ignored.
- Issue in RUN, when `!f_vld || f_rdy`:
  - If `pc < prog_len`: `f_data <= mem[pc]`, `f_pc <= pc`, `f_vld <= 1`, `pc <= pc+1`.
  - If `pc == prog_len`: end of program; behaviour is set by the configuration below.
- `jmp` in RUN with `jmp_addr < prog_len`: `f_vld <= 0` (current word flushed even if `f_rdy` is high) and `pc <= jmp_addr`. Issue resumes on the next edge.
- `jmp` in RUN with `jmp_addr >= prog_len`: ignored, and `err` is set. `jmp` outside RUN is ignored.
- `halt` in RUN: `f_vld <= 0`, `pc <= 0`, go to IDLE.
- Priority within one cycle: `halt` > `jmp` > issue.
- Memory contents are not reset. All registers and outputs reset to 0: `d`, `d_vld`, `f_vld`, `f_data`, `f_pc`, `prog_len`, `busy`, `err`, `pc`.

## Timing
- Host read latency is 1: `ld` sampled at edge N gives `d` and `d_vld` from edge N; `d_vld` drops after one cycle unless `ld` is held.
- `run` sampled at edge N: `busy` is high after N. First issue occurs at edge N+1, so `f_vld` is high after N+1.
- Fetch throughput is one word per cycle while `f_rdy` is held high.
- `f_data` and `f_pc` hold stable while `f_vld && !f_rdy`.
- `jmp` at edge N: `f_vld` is low after N. The target word is valid after N+1.
- `halt` at edge N: `f_vld` and `busy` are low after N.
- `rst_n` low at any time, including mid-RUN, forces all registers to reset values immediately. The first usable edge is after `rst_n` rises.

## Configuration
- `PROG_LOOP_EN` defined: at `pc == prog_len`, issue wraps. `mem[0]` is issued with `f_pc = 0` and `pc <= 1`. RUN continues until `halt`. DONE is unreachable.
- `PROG_LOOP_EN` undefined: at `pc == prog_len`, an issue opportunity sets `f_vld <= 0` and moves to DONE. `busy` drops on the same edge.

## Test plan
- Load and read back:
  - Stimulus: `str` `mem[0..3] = 0xA0..0xA3`, then `ld` `a = 2`.
  - Required: `prog_len = 4`; `d = 0xA2` with a one-cycle `d_vld`.
- Stream without loop, `f_rdy = 1`:
  - Stimulus: `run` on the 4-word program.
  - Required: `f_data` sequence `0xA0..0xA3` on consecutive cycles with `f_pc` 0..3; state DONE after the 4th handshake.
- Backpressure:
  - Stimulus: `f_rdy = 0` for 3 cycles while `f_data = 0xA1`.
  - Required: `f_data` and `f_pc` hold; the next word is 0xA2 one cycle after `f_rdy` rises.
- Jump and error:
  - Stimulus: in RUN, `jmp` to 3, then to 9.
  - Required: after the first jump, `f_vld` is low one cycle, then `f_data = 0xA3`. The jump to 9 is ignored and `err = 1`.
- Errors and halt:
  - Stimulus: `str` during RUN; `run` after `prog_clr`; `halt` mid-stream.
  - Required: memory unchanged and `err = 1`; `run` is rejected with `err = 1`; after `halt`, `f_vld = 0` and state is IDLE.
- Loop and reset (with `PROG_LOOP_EN`):
  - Stimulus: run the 4-word program.
  - Required: `f_pc` sequence 0,1,2,3,0,1.
  - Stimulus: assert `rst_n` low mid-stream.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/prog_store_seq.sv
// prog_store_seq
//   Program store with a built-in fetch sequencer. The host loads instruction
//   words by address and reads them back through a registered port. On `run`
//   the stored program streams out in address order over a valid/ready port,
//   with jump, halt and end-of-program handling.
//
//   Build option: define PROG_LOOP_EN to make the fetch wrap from the last
//   word back to address 0 instead of stopping in DONE.
//
// Ports
//   c          clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   str/ld/a   host write strobe / read strobe / address
//   d_in       host write data
//   d, d_vld   registered host read data and its one-cycle valid
//   prog_clr   clears prog_len and err (ignored while running)
//   run        start or restart fetch from address 0
//   halt       abort fetch, back to IDLE
//   jmp        redirect fetch to jmp_addr
//   f_rdy      downstream ready
//   f_vld      fetch word valid
//   f_data     fetched word
//   f_pc       address of f_data
//   prog_len   highest written address + 1
//   busy       high while running
//   err        sticky error flag
//   state_dbg  FSM state: 0 = IDLE, 1 = RUN, 2 = DONE
//
// Fetch handshake: a word transfers on a rising edge where f_vld && f_rdy.
// While f_vld is high and f_rdy is low, f_data and f_pc hold. f_vld never
// depends combinationally on f_rdy. A jump or halt withdraws f_vld even if
// the current word was being accepted on that edge.

module prog_store_seq #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              c,
   input  logic              rst_n,
   input  logic              str,
   input  logic              ld,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d,
   output logic              d_vld,
   input  logic              prog_clr,
   input  logic              run,
   input  logic              halt,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_addr,
   input  logic              f_rdy,
   output logic              f_vld,
   output logic [DATA_W-1:0] f_data,
   output logic [ADDR_W-1:0] f_pc,
   output logic [ADDR_W:0]   prog_len,
   output logic              busy,
   output logic              err,
   output logic [1:0]        state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   PC_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // pc is one bit wider than an address so it can sit at prog_len == DEPTH
   logic [ADDR_W:0]   pc_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic            in_run;
   logic            wr_en;
   logic            clr_en;
   logic            run_ok;
   logic            run_rej;
   logic            jmp_in_range;
   logic            jmp_ok;
   logic            jmp_bad;
   logic            issue_slot;
   logic            at_end;
   logic [ADDR_W:0] wr_end;
   logic [ADDR_W:0] len_base;
   logic [ADDR_W:0] len_d;
   logic            err_d;

   assign in_run       = (state_q == S_RUN);
   assign wr_en        = str && !in_run;
   assign clr_en       = prog_clr && !in_run;
   assign run_ok       = run && !in_run && (prog_len != '0);
   assign run_rej      = run && !in_run && (prog_len == '0);
   assign jmp_in_range = ({1'b0, jmp_addr} < prog_len);
   assign jmp_ok       = in_run && !halt && jmp && jmp_in_range;
   assign jmp_bad      = in_run && !halt && jmp && !jmp_in_range;
   // An issue opportunity exists when the output slot is empty or being drained
   assign issue_slot   = in_run && !halt && !jmp_ok && (!f_vld || f_rdy);
   // pc cannot pass prog_len: prog_len is frozen while running
   assign at_end       = !(pc_q < prog_len);

   // Program length grows to cover the highest written address; a clear in
   // the same cycle as a write leaves just the written extent.
   assign wr_end   = {1'b0, a} + PC_ONE;
   assign len_base = clr_en ? '0 : prog_len;
   assign len_d    = (wr_en && (wr_end > len_base)) ? wr_end : len_base;

   // New error events win over a clear in the same cycle
   assign err_d = (clr_en ? 1'b0 : err) | (str && in_run) | run_rej | jmp_bad;

   assign busy      = in_run;
   assign state_dbg = state_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (run_ok) state_d = S_RUN;
         end
         S_RUN: begin
            if (halt) begin
               state_d = S_IDLE;
            end else if (issue_slot && at_end) begin
`ifdef PROG_LOOP_EN
               state_d = S_RUN;
`else
               state_d = S_DONE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- storage
   // Not reset. Writes are held off while reset is asserted.
   always_ff @(posedge c) begin
      if (wr_en && rst_n) begin
         mem[a] <= d_in;
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         d        <= '0;
         d_vld    <= 1'b0;
         f_vld    <= 1'b0;
         f_data   <= '0;
         f_pc     <= '0;
         prog_len <= '0;
         err      <= 1'b0;
         pc_q     <= '0;
      end else begin
         // Host read samples the array before this edge's write lands
         d_vld <= ld;
         if (ld) begin
            d <= mem[a];
         end

         prog_len <= len_d;
         err      <= err_d;

         if (run_ok) begin
            pc_q <= '0;
         end

         if (in_run && halt) begin
            f_vld <= 1'b0;
            pc_q  <= '0;
         end else if (jmp_ok) begin
            f_vld <= 1'b0;
            pc_q  <= {1'b0, jmp_addr};
         end else if (issue_slot) begin
            if (!at_end) begin
               f_data <= mem[pc_q[ADDR_W-1:0]];
               f_pc   <= pc_q[ADDR_W-1:0];
               f_vld  <= 1'b1;
               pc_q   <= pc_q + PC_ONE;
            end else begin
`ifdef PROG_LOOP_EN
               f_data <= mem[ADDR_ZERO];
               f_pc   <= ADDR_ZERO;
               f_vld  <= 1'b1;
               pc_q   <= PC_ONE;
`else
               f_vld  <= 1'b0;
`endif
            end
         end
      end
   end

endmodule
